// File: rtl/pipe_skid_reg.sv
// Pipeline stage register with a valid/ready handshake and a 2-entry skid buffer.
// Optional macro PIPE_BUBBLE_ZERO_EN: data outputs read as zero (NOP) while out_valid is low.
module pipe_skid_reg #(
    parameter int DATA_W = 32,
    parameter int PC_W   = 32
) (
    input  logic              clk,
    input  logic              clr_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_instr,
    input  logic [PC_W-1:0]   in_pc,
    input  logic [PC_W-1:0]   in_pc8,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] instr_D,
    output logic [PC_W-1:0]   pc_D,
    output logic [PC_W-1:0]   pc8_D,
    output logic [1:0]        occ
);

    typedef struct packed {
        logic [DATA_W-1:0] instr;
        logic [PC_W-1:0]   pc;
        logic [PC_W-1:0]   pc8;
    } beat_t;

    // Encoding equals occupancy so occ is a plain copy of the state register.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t state;
    beat_t  head;
    beat_t  skid;
    beat_t  in_beat;
    logic   push;
    logic   pop;

    assign in_beat = '{instr: in_instr, pc: in_pc, pc8: in_pc8};

    // Handshake outputs depend only on the state register, never on out_ready.
    assign in_ready  = (state != TWO);
    assign out_valid = (state != EMPTY);
    assign occ       = state;

    assign push = in_valid & in_ready & ~flush;
    assign pop  = out_valid & out_ready;

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            // NOTE: the data registers are reset too, so the outputs read zero out of reset.
            state <= EMPTY;
            head  <= '0;
            skid  <= '0;
        end else if (flush) begin
            // Flush drops only the state; head/skid keep their stale contents.
            state <= EMPTY;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            case (state)
                EMPTY: begin
                    if (push) begin
                        head  <= in_beat;
                        state <= ONE;
                    end
                end
                ONE: begin
                    if (push && pop) begin
                        head <= in_beat;
                    end else if (push) begin
                        skid  <= in_beat;
                        state <= TWO;
                    end else if (pop) begin
                        state <= EMPTY;
                    end
                end
                TWO: begin
                    if (pop) begin
                        head  <= skid;
                        state <= ONE;
                    end
                end
                default: state <= EMPTY;
            endcase
        end
    end

`ifdef PIPE_BUBBLE_ZERO_EN
    assign instr_D = out_valid ? head.instr : '0;
    assign pc_D    = out_valid ? head.pc    : '0;
    assign pc8_D   = out_valid ? head.pc8   : '0;
`else
    assign instr_D = head.instr;
    assign pc_D    = head.pc;
    assign pc8_D   = head.pc8;
`endif

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Self-checking bench for pipe_skid_reg: directed scenarios plus a randomized run
// against a 2-deep FIFO reference model.
module tb_pipe_skid_reg;

    logic        clk;
    logic        clr_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic [31:0] in_pc8;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] instr_D;
    logic [31:0] pc_D;
    logic [31:0] pc8_D;
    logic [1:0]  occ;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pc8;
    } beat_t;

    beat_t model_q[$];

    pipe_skid_reg #(.DATA_W(32), .PC_W(32)) dut (
        .clk       (clk),
        .clr_n     (clr_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_instr  (in_instr),
        .in_pc     (in_pc),
        .in_pc8    (in_pc8),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .instr_D   (instr_D),
        .pc_D      (pc_D),
        .pc8_D     (pc8_D),
        .occ       (occ)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: a FIFO of capacity 2; flush empties it after any same-cycle pop.
    task automatic tick();
        bit push_m;
        bit pop_m;
        push_m = in_valid && (model_q.size() < 2) && !flush;
        pop_m  = (model_q.size() > 0) && out_ready;
        @(posedge clk);
        if (flush) begin
            model_q.delete();
        end else begin
            if (pop_m) void'(model_q.pop_front());
            if (push_m) model_q.push_back('{instr: in_instr, pc: in_pc, pc8: in_pc8});
        end
        @(negedge clk);
    endtask

    task automatic drive(input logic v, input logic [31:0] instr, input logic [31:0] pc);
        in_valid = v;
        in_instr = instr;
        in_pc    = pc;
        in_pc8   = pc + 32'd8;
    endtask

    task automatic test_reset();
        clr_n = 1'b1; flush = 1'b0; out_ready = 1'b0;
        drive(1'b1, 32'h8C01_0004, 32'h0000_0400);
        #2 clr_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
        total++; if (occ !== 2'd0) begin bad++; $display("FAIL reset_occ got=%0d want=0", occ); end
        total++; if ({instr_D, pc_D, pc8_D} !== 96'd0) begin
            bad++; $display("FAIL reset_data got=%h/%h/%h want=0", instr_D, pc_D, pc8_D);
        end
        clr_n = 1'b1;
        model_q.delete();
        tick();
        total++; if (out_valid !== 1'b1 || instr_D !== 32'h8C01_0004 || pc_D !== 32'h400 || pc8_D !== 32'h408) begin
            bad++; $display("FAIL first_beat got v=%b instr=%h pc=%h pc8=%h want v=1 instr=8c010004 pc=400 pc8=408",
                            out_valid, instr_D, pc_D, pc8_D);
        end
        total++; if (occ !== 2'd1) begin bad++; $display("FAIL first_beat_occ got=%0d want=1", occ); end
        // Asynchronous reset while holding a beat: takes effect without a clock edge.
        drive(1'b0, 32'h0, 32'h0);
        clr_n = 1'b0;
        #1;
        total++; if (out_valid !== 1'b0 || occ !== 2'd0 || instr_D !== 32'd0) begin
            bad++; $display("FAIL async_reset got v=%b occ=%0d instr=%h want v=0 occ=0 instr=0", out_valid, occ, instr_D);
        end
        @(negedge clk);
        clr_n = 1'b1;
        model_q.delete();
        out_ready = 1'b1;
        tick();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL no_replay got v=%b want=0", out_valid); end
    endtask

    task automatic test_stream();
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 32'h1000 + i, 32'h3000 + 4 * i);
            total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL stream_in_ready[%0d] got=%b want=1", i, in_ready); end
            tick();
            total++; if (out_valid !== 1'b1 || instr_D !== 32'h1000 + i || pc_D !== 32'h3000 + 4 * i
                         || pc8_D !== 32'h3008 + 4 * i || occ !== 2'd1) begin
                bad++; $display("FAIL stream[%0d] got v=%b instr=%h pc=%h pc8=%h occ=%0d want v=1 instr=%h pc=%h pc8=%h occ=1",
                                i, out_valid, instr_D, pc_D, pc8_D, occ, 32'h1000 + i, 32'h3000 + 4 * i, 32'h3008 + 4 * i);
            end
        end
        drive(1'b0, 32'h0, 32'h0);
        tick();
        total++; if (occ !== 2'd0) begin bad++; $display("FAIL stream_drain occ got=%0d want=0", occ); end
    endtask

    task automatic test_back_pressure();
        out_ready = 1'b0;
        drive(1'b1, 32'h1111_1111, 32'h100);
        tick();
        drive(1'b1, 32'h2222_2222, 32'h104);
        tick();
        drive(1'b0, 32'h0, 32'h0);
        total++; if (occ !== 2'd2 || in_ready !== 1'b0 || instr_D !== 32'h1111_1111) begin
            bad++; $display("FAIL bp_full got occ=%0d in_ready=%b instr=%h want occ=2 in_ready=0 instr=11111111",
                            occ, in_ready, instr_D);
        end
        out_ready = 1'b1;
        tick();
        total++; if (occ !== 2'd1 || in_ready !== 1'b1 || instr_D !== 32'h2222_2222 || pc_D !== 32'h104) begin
            bad++; $display("FAIL bp_pop1 got occ=%0d in_ready=%b instr=%h pc=%h want occ=1 in_ready=1 instr=22222222 pc=104",
                            occ, in_ready, instr_D, pc_D);
        end
        tick();
        total++; if (occ !== 2'd0 || out_valid !== 1'b0) begin
            bad++; $display("FAIL bp_pop2 got occ=%0d v=%b want occ=0 v=0", occ, out_valid);
        end
    endtask

    task automatic test_flush_two();
        out_ready = 1'b0;
        drive(1'b1, 32'hAAAA_0001, 32'h200);
        tick();
        drive(1'b1, 32'hAAAA_0002, 32'h204);
        tick();
        flush = 1'b1;
        drive(1'b1, 32'h3333_3333, 32'h208);
        tick();
        flush = 1'b0;
        drive(1'b0, 32'h0, 32'h0);
        total++; if (occ !== 2'd0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
            bad++; $display("FAIL flush_two got occ=%0d v=%b in_ready=%b want occ=0 v=0 in_ready=1", occ, out_valid, in_ready);
        end
`ifdef PIPE_BUBBLE_ZERO_EN
        total++; if (instr_D !== 32'd0) begin bad++; $display("FAIL flush_bubble instr got=%h want=0", instr_D); end
`else
        total++; if (instr_D !== 32'hAAAA_0001) begin bad++; $display("FAIL flush_stale instr got=%h want=aaaa0001", instr_D); end
`endif
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_dropped[%0d] got v=%b want=0", i, out_valid); end
        end
    endtask

    task automatic test_flush_pop();
        int seen;
        out_ready = 1'b0;
        drive(1'b1, 32'h4444_4444, 32'h300);
        tick();
        seen = 0;
        flush = 1'b1;
        out_ready = 1'b1;
        drive(1'b1, 32'h5555_5555, 32'h304);
        for (int i = 0; i < 4; i++) begin
            if (out_valid && out_ready) begin
                total++; if (instr_D !== 32'h4444_4444) begin
                    bad++; $display("FAIL flush_pop_data[%0d] got=%h want=44444444", i, instr_D);
                end
                seen++;
            end
            tick();
            flush = 1'b0;
            drive(1'b0, 32'h0, 32'h0);
        end
        total++; if (seen !== 1) begin bad++; $display("FAIL flush_pop_count got=%0d want=1", seen); end
        total++; if (occ !== 2'd0) begin bad++; $display("FAIL flush_pop_empty occ got=%0d want=0", occ); end
    endtask

    task automatic test_random();
        int n;
        int errs_before;
        errs_before = bad;
        for (int cyc = 0; cyc < 10000; cyc++) begin
            n = model_q.size();
            total++; if (out_valid !== (n != 0)) begin
                bad++; if (bad - errs_before < 10) $display("FAIL rnd_valid cyc=%0d got=%b want=%b", cyc, out_valid, n != 0);
            end
            total++; if (occ !== n[1:0]) begin
                bad++; if (bad - errs_before < 10) $display("FAIL rnd_occ cyc=%0d got=%0d want=%0d", cyc, occ, n);
            end
            total++; if (in_ready !== (occ != 2'd2)) begin
                bad++; if (bad - errs_before < 10) $display("FAIL rnd_in_ready cyc=%0d got=%b occ=%0d", cyc, in_ready, occ);
            end
            if (n != 0) begin
                total++; if ({instr_D, pc_D, pc8_D} !== model_q[0]) begin
                    bad++; if (bad - errs_before < 10)
                        $display("FAIL rnd_data cyc=%0d got=%h want=%h", cyc, {instr_D, pc_D, pc8_D}, model_q[0]);
                end
            end
`ifdef PIPE_BUBBLE_ZERO_EN
            else begin
                total++; if ({instr_D, pc_D, pc8_D} !== 96'd0) begin
                    bad++; if (bad - errs_before < 10) $display("FAIL rnd_bubble cyc=%0d got=%h want=0", cyc, instr_D);
                end
            end
`endif
            in_valid  = ($urandom_range(0, 99) < 70);
            out_ready = ($urandom_range(0, 99) < 60);
            flush     = ($urandom_range(0, 99) < 3);
            in_instr  = $urandom;
            in_pc     = $urandom;
            in_pc8    = $urandom;
            tick();
        end
        flush = 1'b0;
        in_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_stream();
        test_back_pressure();
        test_flush_two();
        test_flush_pop();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipe_skid_reg.md
# pipe_skid_reg

Parametrised pipeline stage register with a valid/ready handshake and a 2-entry skid buffer. It carries instruction, PC and link-PC fields between stages and supports back-pressure, synchronous flush and single-cycle throughput. It replaces fixed-width enable/clear stage registers at every stage boundary (F/D, D/E, E/M, M/W). Its upstream ready is driven only from its own registered state, so stall paths no longer chain combinationally through the pipeline.

## Interface
- DATA_W, 32, instruction field width
- PC_W, 32, width of each PC field
- clk  input  1  rising-edge clock
- clr_n  input  1  asynchronous active-low reset
- flush  input  1  synchronous flush; empties the stage and drops the input beat offered in the same cycle
- in_valid  input  1  upstream beat valid
- in_ready  output  1  stage can accept a beat
- in_instr  input  DATA_W  instruction
- in_pc  input  PC_W  PC of instruction
- in_pc8  input  PC_W  link address (PC+8)
- out_valid  output  1  downstream beat valid
- out_ready  input  1  downstream accepts the beat (low = stall)
- instr_D  output  DATA_W  head instruction
- pc_D  output  PC_W  head PC
- pc8_D  output  PC_W  head link address
- occ  output  2  current occupancy (0..2), for stall monitors

## Operation
- Storage: head register H (drives the outputs) and skid register S. Each holds {instr, pc, pc8}.
- State register: EMPTY, ONE (H valid), TWO (H and S valid).
- Derived outputs:
  - in_ready = (state != TWO)
  - out_valid = (state != EMPTY)
  - occ = 0, 1 or 2 by state
- Handshake terms: push = in_valid & in_ready & ~flush; pop = out_valid & out_ready.
- Transitions when flush = 0:
  - EMPTY: push → H := in, ONE.
  - ONE: push & pop → H := in, stay ONE. push only → S := in, TWO. pop only → EMPTY.
  - TWO: pop → H := S, ONE. No pop → hold.
- Order is preserved: S is always younger than H.
- Flush has priority over all other events. Next state is EMPTY and any push that cycle is discarded.
- Flush does not clear the data registers (only state).
- Data registers load only on the transfers listed above; they are otherwise held.
- Data is never modified; all fields pass through at their declared widths.

## Timing
- Reset (clr_n low, asynchronous): state EMPTY; H and S all zero; out_valid 0, in_ready 1, occ 0, instr_D/pc_D/pc8_D 0.
- Reset release: beats are accepted on the first rising edge with clr_n high.
- Latency: a beat accepted at edge N is visible on the outputs with out_valid = 1 after edge N, when the stage was EMPTY or popping in ONE.
- Throughput: 1 beat/cycle sustained while out_ready = 1.
- After a single stall cycle the stage fills to TWO. in_ready falls after that edge, with no combinational path from out_ready.
- TWO with out_ready high: one edge to ONE, then full throughput resumes.
- Simultaneous flush + pop: the pop completes downstream (downstream sampled H) and the stage ends EMPTY.
- Reset asserted mid-transfer: all state is lost; no beat is replayed.

## Configuration
- PIPE_BUBBLE_ZERO_EN
  - Defined: instr_D, pc_D and pc8_D are forced to 0 whenever out_valid = 0, so an empty stage presents a NOP (sll $0,$0,0) to decode logic that ignores valid.
  - Undefined: the outputs show H contents regardless of out_valid (stale after a pop or flush). Consumers must qualify them with out_valid.

## Test plan
- Reset: hold clr_n low 3 cycles mid-clock with in_valid = 1 → out_valid 0, in_ready 1, occ 0, all data outputs 0; first beat after release, instr 0x8C010004, appears one edge later.
- Streaming: 8 beats, instr 0x1000+i and pc 0x3000+4i, out_ready tied 1 → outputs match one cycle later, occ stays 1, in_ready never drops.
- Back-pressure: 0x11111111 then 0x22222222 with out_ready low → occ 2, in_ready 0. out_ready high for 2 cycles → 0x11111111 then 0x22222222, in_ready high after the first pop.
- Flush in TWO with in_valid = 1 (0x33333333) → next cycle occ 0, out_valid 0, 0x33333333 never appears. With PIPE_BUBBLE_ZERO_EN, instr_D = 0.
- Flush + pop same cycle in ONE (H = 0x44444444) → downstream captures 0x44444444 once, stage EMPTY afterwards.
- Random valid/ready (10k cycles, seeded) against a FIFO scoreboard → no loss, duplication or reordering; occ never exceeds 2; in_ready always equals (occ != 2).
